// File: rtl/reg_access_ctrl_pkg.sv
// Shared definitions for the register-file access controller: command opcodes,
// frame sizes and the controller state encoding.
package reg_ctrl_pkg;

  localparam logic [7:0] WR_CMD = 8'hAA;
  localparam logic [7:0] RD_CMD = 8'hBB;

  localparam int WR_FRAME_BYTES = 4;
  localparam int RD_FRAME_BYTES = 2;
  localparam int RD_RESP_BYTES  = 2;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    ADDR    = 4'd1,
    DLO     = 4'd2,
    DHI     = 4'd3,
    WRITE   = 4'd4,
    READ    = 4'd5,
    WAIT_RD = 4'd6,
    TX_LO   = 4'd7,
    TX_HI   = 4'd8
  } state_e;

endpackage

// File: rtl/reg_access_ctrl_if.sv
// Byte-stream and register-file bus seen by the access controller.
// master = the controller, slave = the UART pair plus register file around it.
interface reg_access_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
);
  logic [7:0]        RX_Data;
  logic              RX_Valid;
  logic [7:0]        TX_Data;
  logic              TX_Valid;
  logic              TX_Ready;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WrData;
  logic              WrEn;
  logic              RdEn;
  logic [DATA_W-1:0] RdData;
  logic              Busy;
  logic              FrmErr;

  modport master (
    input  RX_Data, RX_Valid, TX_Ready, RdData,
    output TX_Data, TX_Valid, Address, WrData, WrEn, RdEn, Busy, FrmErr
  );

  modport slave (
    output RX_Data, RX_Valid, TX_Ready, RdData,
    input  TX_Data, TX_Valid, Address, WrData, WrEn, RdEn, Busy, FrmErr
  );
endinterface

// File: rtl/reg_access_ctrl_frame_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// flags expiry when the count reaches TIMEOUT-1 (then holds there).
module frame_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clr || !en) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/reg_access_ctrl.sv
// Register-file bus initiator: decodes write/read command frames from the RX
// byte stream, strobes the register file and returns read data over TX.
module reg_access_ctrl
  import reg_ctrl_pkg::*;
#(
  parameter int         ADDR_W  = 3,
  parameter int         DATA_W  = 16,
  parameter logic [7:0] WR_CMD  = reg_ctrl_pkg::WR_CMD,
  parameter logic [7:0] RD_CMD  = reg_ctrl_pkg::RD_CMD,
  parameter int         TIMEOUT = 1024
) (
  input logic                CLK,
  input logic                RST,
  reg_access_ctrl_if.master  bus
);
  state_e     state;
  logic       is_rd;
  logic [7:0] rd_buf_hi;
  logic       in_frame;
  logic       expired;

  assign in_frame = (state == ADDR) || (state == DLO) || (state == DHI);

  frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (bus.RX_Valid),
    .en      (in_frame),
    .expired (expired)
  );

  // A received byte always wins over a timer expiry in the same cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      is_rd       <= 1'b0;
      rd_buf_hi   <= '0;
      bus.Address <= '0;
      bus.WrData  <= '0;
      bus.WrEn    <= 1'b0;
      bus.RdEn    <= 1'b0;
      bus.TX_Data <= '0;
      bus.TX_Valid <= 1'b0;
      bus.Busy    <= 1'b0;
      bus.FrmErr  <= 1'b0;
    end else begin
      bus.WrEn   <= 1'b0;
      bus.RdEn   <= 1'b0;
      bus.FrmErr <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.RX_Valid) begin
            if (bus.RX_Data == WR_CMD || bus.RX_Data == RD_CMD) begin
              is_rd    <= (bus.RX_Data == RD_CMD);
              state    <= ADDR;
              bus.Busy <= 1'b1;
            end else begin
              bus.FrmErr <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (bus.RX_Valid) begin
            bus.Address <= bus.RX_Data[ADDR_W-1:0];
            if (is_rd) begin
              state    <= READ;
              bus.RdEn <= 1'b1;
            end else begin
              state <= DLO;
            end
          end else if (expired) begin
            state      <= IDLE;
            bus.Busy   <= 1'b0;
            bus.FrmErr <= 1'b1;
          end
        end
        DLO: begin
          if (bus.RX_Valid) begin
            bus.WrData[7:0] <= bus.RX_Data;
            state           <= DHI;
          end else if (expired) begin
            state      <= IDLE;
            bus.Busy   <= 1'b0;
            bus.FrmErr <= 1'b1;
          end
        end
        DHI: begin
          if (bus.RX_Valid) begin
            bus.WrData[DATA_W-1:8] <= bus.RX_Data;
            bus.WrEn               <= 1'b1;
            state                  <= WRITE;
          end else if (expired) begin
            state      <= IDLE;
            bus.Busy   <= 1'b0;
            bus.FrmErr <= 1'b1;
          end
        end
        WRITE: begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
        end
        READ: begin
          state <= WAIT_RD;
        end
        WAIT_RD: begin
          rd_buf_hi    <= bus.RdData[DATA_W-1:8];
          bus.TX_Data  <= bus.RdData[7:0];
          bus.TX_Valid <= 1'b1;
          state        <= TX_LO;
        end
        TX_LO: begin
          if (bus.TX_Ready) begin
            bus.TX_Data <= rd_buf_hi;
            state       <= TX_HI;
          end
        end
        TX_HI: begin
          if (bus.TX_Ready) begin
            bus.TX_Valid <= 1'b0;
            bus.Busy     <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl: a frame-level model predicts every
// output each cycle; a small register file answers the read strobes.
module tb_reg_access_ctrl;
  localparam int TMO = 16;

  logic clk;
  logic rst_n;

  reg_access_ctrl_if #(.ADDR_W(3), .DATA_W(16)) bus ();

  reg_access_ctrl #(
    .ADDR_W(3), .DATA_W(16), .WR_CMD(8'hAA), .RD_CMD(8'hBB), .TIMEOUT(TMO)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file attached to the controller
  logic [15:0] rf [8] = '{default: 16'h0};
  always @(posedge clk) begin
    if (bus.WrEn) rf[bus.Address] <= bus.WrData;
    if (bus.RdEn) bus.RdData <= rf[bus.Address];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level model state
  logic [15:0]  mem_m [8] = '{default: 16'h0};
  byte unsigned frm[$];
  byte unsigned txq[$];
  int           gap = 0, lock_cnt = 0, tx_delay = 0;
  logic         cur_wren = 0, cur_rden = 0, cur_err = 0, cur_busy = 0, cur_txv = 0;
  logic [7:0]   cur_txd = 0;
  logic [2:0]   cur_addr = 0;
  logic [15:0]  cur_wrd = 0;
  logic         nx_wren, nx_rden, nx_err, nx_busy, nx_txv, locked;
  logic [7:0]   nx_txd;
  logic [2:0]   nx_addr;
  logic [15:0]  nx_wrd;
  int           wr_seen = 0, rd_seen = 0, err_seen = 0;
  byte unsigned tx_log[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs", {bus.WrEn, bus.RdEn, bus.FrmErr, bus.Busy, bus.TX_Valid,
                            bus.TX_Data, bus.Address, bus.WrData}, 32'h0);
      frm.delete(); txq.delete();
      gap = 0; lock_cnt = 0; tx_delay = 0;
      cur_wren = 0; cur_rden = 0; cur_err = 0; cur_busy = 0; cur_txv = 0;
      cur_txd = 0; cur_addr = 0; cur_wrd = 0;
    end else begin
      chk("wren", bus.WrEn, cur_wren);
      chk("rden", bus.RdEn, cur_rden);
      chk("frmerr", bus.FrmErr, cur_err);
      chk("busy", bus.Busy, cur_busy);
      chk("address", bus.Address, cur_addr);
      chk("wrdata", bus.WrData, cur_wrd);
      chk("tx_valid", bus.TX_Valid, cur_txv);
      if (cur_txv) chk("tx_data", bus.TX_Data, cur_txd);
      wr_seen += int'(bus.WrEn);
      rd_seen += int'(bus.RdEn);
      err_seen += int'(bus.FrmErr);
      if (bus.TX_Valid && bus.TX_Ready) tx_log.push_back(bus.TX_Data);

      // Predict the next cycle from this cycle's inputs
      nx_wren = 0; nx_rden = 0; nx_err = 0;
      nx_addr = cur_addr; nx_wrd = cur_wrd; nx_txv = cur_txv; nx_txd = cur_txd;
      locked = (lock_cnt > 0) || (txq.size() > 0);
      if (lock_cnt > 0) lock_cnt--;
      if (cur_txv) begin
        if (bus.TX_Ready) begin
          void'(txq.pop_front());
          if (txq.size() == 0) nx_txv = 0;
          else nx_txd = txq[0];
        end
      end else if (tx_delay > 0) begin
        tx_delay--;
        if (tx_delay == 0) begin
          nx_txv = 1;
          nx_txd = txq[0];
        end
      end
      if (!locked) begin
        if (frm.size() == 0) begin
          if (bus.RX_Valid) begin
            if (bus.RX_Data == 8'hAA || bus.RX_Data == 8'hBB) begin
              frm.push_back(bus.RX_Data);
              gap = 0;
            end else begin
              nx_err = 1;
            end
          end
        end else if (bus.RX_Valid) begin
          frm.push_back(bus.RX_Data);
          gap = 0;
          if (frm.size() == 2) nx_addr = bus.RX_Data[2:0];
          if (frm.size() == 3) nx_wrd[7:0] = bus.RX_Data;
          if (frm.size() == 4) nx_wrd[15:8] = bus.RX_Data;
          if (frm[0] == 8'hBB && frm.size() == 2) begin
            nx_rden = 1;
            txq.delete();
            txq.push_back(mem_m[nx_addr][7:0]);
            txq.push_back(mem_m[nx_addr][15:8]);
            tx_delay = 2;
            frm.delete();
          end else if (frm[0] == 8'hAA && frm.size() == 4) begin
            nx_wren = 1;
            mem_m[nx_addr] = nx_wrd;
            lock_cnt = 1;
            frm.delete();
          end
        end else if (gap == TMO - 1) begin
          nx_err = 1;
          frm.delete();
        end else begin
          gap++;
        end
      end
      nx_busy = (frm.size() > 0) || (lock_cnt > 0) || (txq.size() > 0);
      cur_wren = nx_wren; cur_rden = nx_rden; cur_err = nx_err; cur_busy = nx_busy;
      cur_txv = nx_txv; cur_txd = nx_txd; cur_addr = nx_addr; cur_wrd = nx_wrd;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.RX_Data  = b;
    bus.RX_Valid = 1'b1;
    tick();
    bus.RX_Valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.RX_Valid = 1'b0;
    bus.RX_Data  = 8'h00;
    bus.TX_Ready = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // 1: write 0x1234 to address 5, read it back
    send(8'hAA); send(8'h05); send(8'h34); send(8'h12);
    tick(3);
    chk("t1_wr_count", wr_seen, 1);
    chk("t1_rf5", rf[5], 16'h1234);
    chk("t1_address", bus.Address, 3'd5);
    chk("t1_wrdata", bus.WrData, 16'h1234);
    send(8'hBB); send(8'h05);
    tick(6);
    chk("t1_rd_count", rd_seen, 1);
    chk("t1_tx_count", tx_log.size(), 2);
    chk("t1_tx_lo", tx_log[0], 8'h34);
    chk("t1_tx_hi", tx_log[1], 8'h12);
    chk("t1_busy", bus.Busy, 1'b0);

    // 2: bad opcode in IDLE
    send(8'h7E);
    tick(2);
    chk("t2_err_count", err_seen, 1);
    chk("t2_wr_count", wr_seen, 1);
    chk("t2_rd_count", rd_seen, 1);
    chk("t2_busy", bus.Busy, 1'b0);

    // 3: timeout after opcode+address, then a clean write to address 2
    send(8'hAA); send(8'h02);
    tick(10);
    chk("t3_busy_mid", bus.Busy, 1'b1);
    chk("t3_err_mid", err_seen, 1);
    tick(10);
    chk("t3_err_count", err_seen, 2);
    chk("t3_busy", bus.Busy, 1'b0);
    chk("t3_wr_none", wr_seen, 1);
    send(8'hAA); send(8'h02); send(8'h78); send(8'h56);
    tick(3);
    chk("t3_rf2", rf[2], 16'h5678);
    chk("t3_wr_count", wr_seen, 2);

    // 4: read with TX_Ready held low
    bus.TX_Ready = 1'b0;
    send(8'hBB); send(8'h02);
    tick(20);
    chk("t4_tx_valid", bus.TX_Valid, 1'b1);
    chk("t4_tx_data", bus.TX_Data, 8'h78);
    chk("t4_tx_none", tx_log.size(), 2);
    bus.TX_Ready = 1'b1;
    tick(4);
    chk("t4_tx_count", tx_log.size(), 4);
    chk("t4_tx_lo", tx_log[2], 8'h78);
    chk("t4_tx_hi", tx_log[3], 8'h56);
    chk("t4_busy", bus.Busy, 1'b0);

    // 5: bytes injected during WAIT_RD and TX_HI are ignored
    bus.TX_Ready = 1'b0;
    send(8'hBB); send(8'h05);
    tick(1);
    send(8'hAA);
    tick(2);
    bus.TX_Ready = 1'b1;
    tick(1);
    bus.TX_Ready = 1'b0;
    send(8'h7E);
    bus.TX_Ready = 1'b1;
    tick(3);
    chk("t5_tx_count", tx_log.size(), 6);
    chk("t5_tx_lo", tx_log[4], 8'h34);
    chk("t5_tx_hi", tx_log[5], 8'h12);
    chk("t5_err_count", err_seen, 2);
    chk("t5_rd_count", rd_seen, 3);
    chk("t5_busy", bus.Busy, 1'b0);

    // 6: reset mid-frame, then a full write to address 1
    send(8'hAA); send(8'h01); send(8'hFF);
    rst_n = 1'b0;
    tick(2);
    chk("t6_rst_address", bus.Address, 3'd0);
    chk("t6_rst_wrdata", bus.WrData, 16'h0);
    chk("t6_rst_busy", bus.Busy, 1'b0);
    rst_n = 1'b1;
    tick(1);
    chk("t6_rf1_untouched", rf[1], 16'h0);
    send(8'hAA); send(8'h01); send(8'hCD); send(8'hAB);
    tick(3);
    chk("t6_rf1", rf[1], 16'hABCD);
    chk("t6_wr_count", wr_seen, 3);
    chk("t6_address", bus.Address, 3'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
